// File: rtl/fpga_pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: counting mode,
// counter direction and default sizing.
package fpga_pwm_pkg;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_t;

   localparam int unsigned PWM_WIDTH_DEF    = 8;
   localparam int unsigned PWM_CHANNELS_DEF = 4;

endpackage

// File: rtl/fpga_pwm_cmp.sv
// One PWM channel: active duty register plus registered compare output.
// Ports:
//   clk, rst   clock, async active-high reset
//   en         run enable; low forces the output low on the next edge
//   running    counter is producing a valid period
//   cnt        shared period counter
//   apply      boundary update strobe; loads duty_next as the active duty
//   duty_next  duty value to become active at the boundary
//   pwm        registered PWM output
module fpga_pwm_cmp
   import fpga_pwm_pkg::*;
#(
   parameter int unsigned WIDTH = PWM_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             running,
   input  logic [WIDTH-1:0] cnt,
   input  logic             apply,
   input  logic [WIDTH-1:0] duty_next,
   output logic             pwm
);

   logic [WIDTH-1:0] duty_act;

   // The compare sees the duty in force before this edge, so a duty
   // change applied at a boundary only affects the following period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_act <= '0;
         pwm      <= 1'b0;
      end else begin
         if (apply) begin
            duty_act <= duty_next;
         end
         pwm <= en && running && (cnt < duty_act);
      end
   end

endmodule

// File: rtl/fpga_pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, CHANNELS duty
// comparators, edge- or center-aligned, with double-buffered settings.
// Ports:
//   clk, rst     clock, async active-high reset
//   en           run enable
//   load         strobe capturing period/duty/center_mode into the shadow
//   period       period value P
//   duty         per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   center_mode  0 = edge-aligned, 1 = center-aligned
//   pwm          registered PWM outputs
//   cycle_start  pulse in the first cycle of each period
//   pending      shadow holds values not yet applied
module fpga_pwm_multi
   import fpga_pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = PWM_WIDTH_DEF,
   parameter int unsigned CHANNELS = PWM_CHANNELS_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      load,
   input  logic [WIDTH-1:0]          period,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      center_mode,
   output logic [CHANNELS-1:0]       pwm,
   output logic                      cycle_start,
   output logic                      pending
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0]          cnt;
   pwm_dir_t                  dir;
   logic                      running;
   logic [WIDTH-1:0]          act_period;
   pwm_mode_t                 act_mode;
   logic [WIDTH-1:0]          shd_period;
   logic [CHANNELS*WIDTH-1:0] shd_duty;
   pwm_mode_t                 shd_mode;

   logic                      at_end;
   logic                      boundary;
   logic                      apply;
   logic [WIDTH-1:0]          new_period;
   logic [CHANNELS*WIDTH-1:0] new_duty;
   pwm_mode_t                 new_mode;
   logic [WIDTH-1:0]          eff_period;
   pwm_mode_t                 eff_mode;

   // A load in the boundary cycle bypasses the shadow and goes straight
   // to the active set, so pending never rises for it.
   always_comb begin
      at_end     = (act_mode == PWM_EDGE) ? (cnt == '0)
                                          : ((dir == DIR_DOWN) && (cnt == '0));
      boundary   = en && (!running || at_end);
      apply      = boundary && (load || pending);
      new_period = load ? period : shd_period;
      new_duty   = load ? duty : shd_duty;
      new_mode   = load ? pwm_mode_t'(center_mode) : shd_mode;
      eff_period = apply ? new_period : act_period;
      eff_mode   = apply ? new_mode : act_mode;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         dir         <= DIR_UP;
         running     <= 1'b0;
         cycle_start <= 1'b0;
      end else if (!en) begin
         cnt         <= '0;
         dir         <= DIR_UP;
         running     <= 1'b0;
         cycle_start <= 1'b0;
      end else begin
         running     <= 1'b1;
         cycle_start <= boundary;
         if (boundary) begin
            cnt <= (eff_mode == PWM_EDGE) ? eff_period : '0;
            dir <= DIR_UP;
         end else if (act_mode == PWM_EDGE) begin
            cnt <= cnt - ONE;
         end else if (dir == DIR_UP) begin
            // Peak is held for two cycles: once going up, once going down.
            if (cnt == act_period) begin
               dir <= DIR_DOWN;
            end else begin
               cnt <= cnt + ONE;
            end
         end else begin
            cnt <= cnt - ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shd_period <= '0;
         shd_duty   <= '0;
         shd_mode   <= PWM_EDGE;
         act_period <= '0;
         act_mode   <= PWM_EDGE;
         pending    <= 1'b0;
      end else begin
         if (load) begin
            shd_period <= period;
            shd_duty   <= duty;
            shd_mode   <= pwm_mode_t'(center_mode);
         end
         if (apply) begin
            act_period <= new_period;
            act_mode   <= new_mode;
            pending    <= 1'b0;
         end else if (load) begin
            pending    <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
      fpga_pwm_cmp #(
         .WIDTH(WIDTH)
      ) u_cmp (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .running   (running),
         .cnt       (cnt),
         .apply     (apply),
         .duty_next (new_duty[g*WIDTH +: WIDTH]),
         .pwm       (pwm[g])
      );
   end

endmodule

// File: tb/tb_fpga_pwm_multi.sv
// Bench for fpga_pwm_multi: directed scenarios plus randomized stimulus,
// checked against a period-position reference model.
module tb_fpga_pwm_multi;

   localparam int unsigned W  = 8;
   localparam int unsigned CH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            load;
   logic [W-1:0]    period;
   logic [CH*W-1:0] duty;
   logic            center_mode;
   logic [CH-1:0]   pwm;
   logic            cycle_start;
   logic            pending;

   always #5 clk = ~clk;

   fpga_pwm_multi #(
      .WIDTH    (W),
      .CHANNELS (CH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .load        (load),
      .period      (period),
      .duty        (duty),
      .center_mode (center_mode),
      .pwm         (pwm),
      .cycle_start (cycle_start),
      .pending     (pending)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: position k within the current period plus active
   // and shadow settings; the counter value is derived arithmetically.
   bit          m_run;
   int unsigned m_k;
   int unsigned m_p;
   int unsigned m_mode;
   int unsigned m_d[CH];
   int unsigned s_p;
   int unsigned s_mode;
   int unsigned s_d[CH];
   bit          m_pend;
   logic [CH-1:0] e_pwm;
   bit          e_cs;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned m_len();
      return (m_mode == 0) ? m_p + 1 : 2 * (m_p + 1);
   endfunction

   function automatic int unsigned m_cnt();
      if (m_mode == 0) return m_p - m_k;
      return (m_k <= m_p) ? m_k : 2 * m_p + 1 - m_k;
   endfunction

   task automatic model_reset();
      m_run = 0; m_k = 0; m_p = 0; m_mode = 0; s_p = 0; s_mode = 0; m_pend = 0;
      for (int i = 0; i < int'(CH); i++) begin
         m_d[i] = 0;
         s_d[i] = 0;
      end
      e_pwm = '0;
      e_cs  = 0;
   endtask

   task automatic model_step();
      int unsigned c;
      bit bnd;
      c   = m_run ? m_cnt() : 0;
      bnd = en && (!m_run || (m_k == m_len() - 1));
      for (int i = 0; i < int'(CH); i++) e_pwm[i] = en && m_run && (c < m_d[i]);
      e_cs = bnd;
      if (load) begin
         s_p = period; s_mode = center_mode;
         for (int i = 0; i < int'(CH); i++) s_d[i] = duty[i*W +: W];
      end
      if (bnd && (load || m_pend)) begin
         m_p = s_p; m_mode = s_mode;
         for (int i = 0; i < int'(CH); i++) m_d[i] = s_d[i];
         m_pend = 0;
      end else if (load) begin
         m_pend = 1;
      end
      if (!en) begin
         m_run = 0; m_k = 0;
      end else if (bnd) begin
         m_run = 1; m_k = 0;
      end else begin
         m_k++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_val("pwm", 32'(pwm), 32'(e_pwm));
      check_val("cycle_start", 32'(cycle_start), 32'(e_cs));
      check_val("pending", 32'(pending), 32'(m_pend));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input int unsigned p, input int unsigned d0, input int unsigned d1,
                          input bit mode);
      period      = W'(p);
      duty        = {W'(d1), W'(d0)};
      center_mode = mode;
      load        = 1'b1;
      tick();
      load        = 1'b0;
   endtask

   // Called just after a tick; pulses reset between clock edges.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_pwm", 32'(pwm), 32'd0);
      check_val("rst_cs", 32'(cycle_start), 32'd0);
      check_val("rst_pending", 32'(pending), 32'd0);
      model_reset();
      #1 rst = 1'b0;
   endtask

   initial begin
      int hi0, hi1, ncs;
      bool_wait: begin end
      rst = 1'b1; en = 1'b0; load = 1'b0; period = '0; duty = '0; center_mode = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_pwm", 32'(pwm), 32'd0);
      check_val("reset_cs", 32'(cycle_start), 32'd0);
      check_val("reset_pending", 32'(pending), 32'd0);
      rst = 1'b0;

      // 1: edge P=4, D0=2, D1=0
      do_load(4, 2, 0, 1'b0);
      check_val("t1_pending", 32'(pending), 32'd1);
      en = 1'b1;
      tick();
      hi0 = 0; hi1 = 0; ncs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         hi0 += int'(pwm[0]);
         hi1 += int'(pwm[1]);
         ncs += int'(cycle_start);
      end
      check_val("t1_hi0", 32'(hi0), 32'd4);
      check_val("t1_hi1", 32'(hi1), 32'd0);
      check_val("t1_cs", 32'(ncs), 32'd2);

      // 2: duty above period, then D=P
      do_load(4, 5, 200, 1'b0);
      run(15);
      do_load(4, 4, 1, 1'b0);
      run(15);

      // 3: center P=3, D=2
      do_load(3, 2, 2, 1'b1);
      run(10);
      hi0 = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         hi0 += int'(pwm[0]);
      end
      check_val("t3_hi0", 32'(hi0), 32'd4);

      // 4: mid-period reload
      do_load(9, 3, 3, 1'b0);
      run(14);
      do_load(4, 1, 1, 1'b0);
      run(20);

      // 5: load exactly in the boundary cycle
      begin
         int guard = 0;
         while (!(m_run && en && m_k == m_len() - 1) && guard < 50) begin
            tick();
            guard++;
         end
         check_val("t5_found_boundary", 32'(guard < 50), 32'd1);
      end
      do_load(6, 3, 7, 1'b0);
      check_val("t5_pending", 32'(pending), 32'd0);
      run(16);

      // 6: en drop while high, then async reset
      begin
         int guard = 0;
         while (pwm[0] !== 1'b1 && guard < 50) begin
            tick();
            guard++;
         end
         check_val("t6_found_high", 32'(guard < 50), 32'd1);
      end
      en = 1'b0;
      tick();
      check_val("t6_en_drop", 32'(pwm), 32'd0);
      en = 1'b1;
      run(5);
      async_reset();
      run(15);

      // Randomized stimulus
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int unsigned p;
         en   = ($urandom_range(0, 99) < 96);
         load = ($urandom_range(0, 99) < 6);
         if (load) begin
            p           = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            period      = W'(p);
            center_mode = $urandom_range(0, 1);
            for (int i = 0; i < int'(CH); i++)
               duty[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'(255) : W'($urandom_range(0, p + 2));
         end
         tick();
         load = 1'b0;
         if ($urandom_range(0, 599) == 0) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
